// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer with synchronizer, edge pulses and
// long-press (hold) detection. Every channel owns its own synchronizer,
// FSM, debounce counter and hold counter.
//
//   state     | meaning
//   STABLE_LO | accepted level is 0, input quiet
//   PEND_HI   | input reads 1, counting toward acceptance of a press
//   STABLE_HI | accepted level is 1, hold timer running
//   PEND_LO   | input reads 0, counting toward acceptance of a release
module btn_debounce #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 100000000
) (
    input  logic            sysClk,
    input  logic            sysRstb,
    input  logic [N_CH-1:0] btnIn,
    output logic [N_CH-1:0] btnLevel,
    output logic [N_CH-1:0] btnRise,
    output logic [N_CH-1:0] btnFall,
    output logic [N_CH-1:0] btnHold
);

    localparam int MAX_C = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    // The sample that enters a pending state is sample 1 with the counter at 0,
    // so acceptance happens on the sample where the counter already holds D-2.
    localparam logic [CW-1:0] DB_TC    = CW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
    localparam logic [CW-1:0] HOLD_TC  = CW'((HOLD_CYCLES >= 1) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_t                 state_q, state_d;
        logic [CW-1:0]          deb_q, deb_d;
        logic [CW-1:0]          hold_q, hold_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   hevt_q, hevt_d;

        assign s = sync_q[SYNC_STAGES-1];

        // Synchronizer chain for the raw asynchronous input.
        always_ff @(posedge sysClk or negedge sysRstb) begin
            if (!sysRstb) sync_q <= '0;
            else          sync_q <= {sync_q[SYNC_STAGES-2:0], btnIn[i]};
        end

        // State, counters and registered outputs.
        always_ff @(posedge sysClk or negedge sysRstb) begin
            if (!sysRstb) begin
                state_q <= STABLE_LO;
                deb_q   <= '0;
                hold_q  <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                hevt_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                deb_q   <= deb_d;
                hold_q  <= hold_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                hevt_q  <= hevt_d;
            end
        end

        // Next-state, counter and pulse decode.
        always_comb begin
            state_d = state_q;
            deb_d   = deb_q;
            hold_d  = hold_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            hevt_d  = 1'b0;

            // Hold timing keeps running through a pending release so that a
            // rejected release does not restart it; it saturates at HOLD_MAX,
            // which also limits the hold pulse to one per press.
            if ((state_q == STABLE_HI || state_q == PEND_LO) &&
                (HOLD_CYCLES > 0) && (hold_q != HOLD_MAX)) begin
                hold_d = hold_q + CW'(1);
                hevt_d = (hold_q == HOLD_TC);
            end

            case (state_q)
                STABLE_LO: begin
                    hold_d = '0;
                    if (s) begin
                        deb_d = '0;
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = STABLE_HI;
                            level_d = 1'b1;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = PEND_HI;
                        end
                    end
                end
                PEND_HI: begin
                    if (!s) begin
                        state_d = STABLE_LO;
                        deb_d   = '0;
                    end else if (deb_q == DB_TC) begin
                        state_d = STABLE_HI;
                        deb_d   = '0;
                        hold_d  = '0;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        deb_d = deb_q + CW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        deb_d = '0;
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = STABLE_LO;
                            hold_d  = '0;
                            level_d = 1'b0;
                            fall_d  = 1'b1;
                            hevt_d  = 1'b0;
                        end else begin
                            state_d = PEND_LO;
                        end
                    end
                end
                PEND_LO: begin
                    if (s) begin
                        state_d = STABLE_HI;
                        deb_d   = '0;
                    end else if (deb_q == DB_TC) begin
                        // Release wins over a coincident hold so pulses stay exclusive.
                        state_d = STABLE_LO;
                        deb_d   = '0;
                        hold_d  = '0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        hevt_d  = 1'b0;
                    end else begin
                        deb_d = deb_q + CW'(1);
                    end
                end
                default: begin
                    state_d = STABLE_LO;
                    deb_d   = '0;
                    hold_d  = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign btnLevel[i] = level_q;
        assign btnRise[i]  = rise_q;
        assign btnFall[i]  = fall_q;
        assign btnHold[i]  = hevt_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with N_CH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, HOLD_CYCLES=10 (accept latency 6 edges, hold 10 after rise).
module tb_btn_debounce;

    logic       sysClk = 1'b0;
    logic       sysRstb;
    logic [3:0] btnIn;
    logic [3:0] btnLevel;
    logic [3:0] btnRise;
    logic [3:0] btnFall;
    logic [3:0] btnHold;

    int n_chk = 0;
    int n_bad = 0;

    btn_debounce #(
        .N_CH(4),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10)
    ) dut (
        .sysClk(sysClk),
        .sysRstb(sysRstb),
        .btnIn(btnIn),
        .btnLevel(btnLevel),
        .btnRise(btnRise),
        .btnFall(btnFall),
        .btnHold(btnHold)
    );

    always #5 sysClk = ~sysClk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    // Run n edges; pulses on channels ch expected at the given edge (0 = never),
    // level switches from lvl_a to lvl_b starting at edge lvl_at.
    task automatic watch(input string name, input int n, input int rise_at,
                         input int fall_at, input int hold_at, input logic [3:0] ch,
                         input logic [3:0] lvl_a, input logic [3:0] lvl_b, input int lvl_at);
        for (int k = 1; k <= n; k++) begin
            tick();
            chk($sformatf("%s rise k=%0d", name, k), {28'd0, btnRise}, {28'd0, (k == rise_at) ? ch : 4'b0000});
            chk($sformatf("%s fall k=%0d", name, k), {28'd0, btnFall}, {28'd0, (k == fall_at) ? ch : 4'b0000});
            chk($sformatf("%s hold k=%0d", name, k), {28'd0, btnHold}, {28'd0, (k == hold_at) ? ch : 4'b0000});
            chk($sformatf("%s level k=%0d", name, k), {28'd0, btnLevel}, {28'd0, (k >= lvl_at) ? lvl_b : lvl_a});
        end
    endtask

    initial begin
        sysRstb = 1'b0;
        btnIn   = 4'b0000;
        #1;
        chk("reset level", {28'd0, btnLevel}, 32'd0);
        chk("reset rise",  {28'd0, btnRise},  32'd0);
        chk("reset fall",  {28'd0, btnFall},  32'd0);
        chk("reset hold",  {28'd0, btnHold},  32'd0);
        tick();
        tick();
        sysRstb = 1'b1;
        watch("idle", 4, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);

        // clean press on ch0 held 30 cycles, hold pulse once, then release
        btnIn = 4'b0001;
        watch("press0", 30, 6, 0, 16, 4'b0001, 4'b0000, 4'b0001, 6);
        btnIn = 4'b0000;
        watch("release0", 8, 0, 6, 0, 4'b0001, 4'b0001, 4'b0000, 6);

        // 7-cycle press: rise and fall but no hold
        btnIn = 4'b0001;
        watch("short_press", 7, 6, 0, 0, 4'b0001, 4'b0000, 4'b0001, 6);
        btnIn = 4'b0000;
        watch("short_rel", 12, 0, 6, 0, 4'b0001, 4'b0001, 4'b0000, 6);

        // bounce on ch1: 10 segments of 2 cycles, then settle high
        for (int seg = 0; seg < 10; seg++) begin
            btnIn = (seg % 2 == 0) ? 4'b0010 : 4'b0000;
            watch("bounce", 2, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1);
        end
        btnIn = 4'b0010;
        watch("bounce_settle", 8, 6, 0, 0, 4'b0010, 4'b0000, 4'b0010, 6);
        btnIn = 4'b0000;
        watch("bounce_rel", 8, 0, 6, 0, 4'b0010, 4'b0010, 4'b0000, 6);

        // 3-cycle glitch on ch2 must be ignored
        btnIn = 4'b0100;
        watch("glitch_hi", 3, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1);
        btnIn = 4'b0000;
        watch("glitch_lo", 10, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1);

        // simultaneous press and release on ch0 and ch3
        btnIn = 4'b1001;
        watch("simul", 20, 6, 0, 16, 4'b1001, 4'b0000, 4'b1001, 6);
        btnIn = 4'b0000;
        watch("simul_rel", 8, 0, 6, 0, 4'b1001, 4'b1001, 4'b0000, 6);

        // reset mid-debounce on ch3 while ch0 is accepted high
        btnIn = 4'b0001;
        watch("pre_rst", 8, 6, 0, 0, 4'b0001, 4'b0000, 4'b0001, 6);
        btnIn = 4'b1001;
        watch("pend3", 5, 0, 0, 0, 4'b1000, 4'b0001, 4'b0001, 1);
        #2;
        sysRstb = 1'b0;
        #1;
        chk("async_rst level", {28'd0, btnLevel}, 32'd0);
        chk("async_rst rise",  {28'd0, btnRise},  32'd0);
        chk("async_rst hold",  {28'd0, btnHold},  32'd0);
        watch("in_rst", 2, 0, 0, 0, 4'b1001, 4'b0000, 4'b0000, 1);
        sysRstb = 1'b1;
        watch("post_rst", 20, 6, 0, 16, 4'b1001, 4'b0000, 4'b1001, 6);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
